node_injector: RTL and testbench

- Transmit-side network interface for one mesh node: the counterpart that feeds a node router's local input port (port 4).
- Accepts neuron-core requests (destination x/y plus payload) and prepends the net-address header in the top NET_WIDTH bits of the stream.
- Buffers packets in a FIFO and presents them to the router with a valid/ready handshake.
- Self-addressed packets bypass the mesh and are delivered on a loopback output.

---
 rtl/node_injector.sv | 125 ++++++++++++
 tb/tb_node_injector.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/node_injector.sv
// Transmit-side network interface for one mesh node: tags core requests with a
// {dst_y, dst_x} header, queues them for the router and loops self-addressed packets back.
module node_injector #(
    parameter int STREAM_WIDTH = 144,
    parameter int NET_WIDTH    = 4,
    parameter int NW_HALF      = 2,
    parameter int SELF_X       = 0,
    parameter int SELF_Y       = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [NW_HALF-1:0]                 req_dst_x,
    input  logic [NW_HALF-1:0]                 req_dst_y,
    input  logic [STREAM_WIDTH-NET_WIDTH-1:0]  req_payload,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [STREAM_WIDTH-1:0]            out_stream,
    output logic                               loop_valid,
    output logic [STREAM_WIDTH-1:0]            loop_stream,
    output logic [$clog2(FIFO_DEPTH):0]        occupancy,
    output logic [15:0]                        tx_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [NW_HALF-1:0] SELF_X_L = NW_HALF'(SELF_X);
    localparam logic [NW_HALF-1:0] SELF_Y_L = NW_HALF'(SELF_Y);
    localparam logic [OCC_W-1:0]   DEPTH_L  = OCC_W'(FIFO_DEPTH);

    logic [STREAM_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [OCC_W-1:0]        r_occ;
    logic [15:0]             r_tx_count;
    logic                    r_loop_valid;
    logic [STREAM_WIDTH-1:0] r_loop_stream;

    logic                    w_self;
    logic                    w_full;
    logic                    w_ready;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_loop;
    logic [STREAM_WIDTH-1:0] w_packet;

    // Request decode: readiness depends only on stored state and the request address.
    always_comb begin
        w_self   = (req_dst_x == SELF_X_L) && (req_dst_y == SELF_Y_L);
        w_full   = (r_occ == DEPTH_L);
        w_ready  = rst_n & (w_self | ~w_full);
        w_loop   = req_valid & w_ready & w_self;
        w_push   = req_valid & w_ready & ~w_self;
        w_pop    = (r_occ != {OCC_W{1'b0}}) & out_ready;
        w_packet = {req_dst_y, req_dst_x, req_payload};
    end

    // Packet storage and pointers; storage is cleared so stale packets never reappear after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {STREAM_WIDTH{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_packet;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

    // Occupancy tracked apart from the pointers so full and empty are unambiguous.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ <= {OCC_W{1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Router hand-off counter and the self-addressed loopback path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_count    <= 16'h0000;
            r_loop_valid  <= 1'b0;
            r_loop_stream <= {STREAM_WIDTH{1'b0}};
        end else begin
            if (w_pop) begin
                r_tx_count <= r_tx_count + 16'h0001;
            end else begin
                r_tx_count <= r_tx_count;
            end
            r_loop_valid <= w_loop;
            if (w_loop) begin
                r_loop_stream <= w_packet;
            end else begin
                r_loop_stream <= r_loop_stream;
            end
        end
    end

    assign req_ready   = w_ready;
    assign out_valid   = (r_occ != {OCC_W{1'b0}});
    assign out_stream  = r_mem[r_rd_ptr];
    assign loop_valid  = r_loop_valid;
    assign loop_stream = r_loop_stream;
    assign occupancy   = r_occ;
    assign tx_count    = r_tx_count;

endmodule

// File: tb/tb_node_injector.sv
// Scoreboard bench for node_injector at node (1,1): a queue-based reference model
// predicts accepts, router packets and loopback pulses from randomized and directed traffic.
module tb_node_injector;

    localparam int SW    = 144;
    localparam int PW    = 140;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_dst_x;
    logic [1:0]    req_dst_y;
    logic [PW-1:0] req_payload;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_stream;
    logic          loop_valid;
    logic [SW-1:0] loop_stream;
    logic [2:0]    occupancy;
    logic [15:0]   tx_count;

    node_injector #(
        .STREAM_WIDTH(SW), .NET_WIDTH(4), .NW_HALF(2),
        .SELF_X(1), .SELF_Y(1), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_payload(req_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_stream(out_stream),
        .loop_valid(loop_valid), .loop_stream(loop_stream),
        .occupancy(occupancy), .tx_count(tx_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] loop_q[$];
    int            m_occ = 0;
    logic [15:0]   m_tx = 16'h0000;
    logic [SW-1:0] m_last_loop = '0;
    logic          m_rst = 1'b1;

    task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic is_self(input logic [1:0] x, input logic [1:0] y);
        return (x == 2'd1) && (y == 2'd1);
    endfunction

    // Reference model: spec rules applied to the inputs seen at each rising edge.
    initial forever begin
        logic [SW-1:0] pkt;
        logic          pop;
        @(posedge clk);
        m_rst = !rst_n;
        if (!rst_n) begin
            m_occ = 0;
            m_tx  = 16'h0000;
            m_last_loop = '0;
            exp_q.delete();
            loop_q.delete();
        end else begin
            pkt = {req_dst_y, req_dst_x, req_payload};
            pop = (m_occ > 0) && out_ready;
            if (req_valid && is_self(req_dst_x, req_dst_y)) begin
                loop_q.push_back(pkt);
                m_last_loop = pkt;
            end else if (req_valid && m_occ < DEPTH) begin
                exp_q.push_back(pkt);
                m_occ++;
            end
            if (pop) begin
                m_occ--;
                m_tx = m_tx + 16'h0001;
            end
        end
    end

    // Monitor: compares DUT outputs with the model on every falling edge.
    initial forever begin
        logic [SW-1:0] e;
        logic          exp_rdy;
        @(negedge clk);
        exp_rdy = rst_n && (is_self(req_dst_x, req_dst_y) || m_occ < DEPTH);
        chk("req_ready", SW'(req_ready), SW'(exp_rdy));
        chk("out_valid", SW'(out_valid), SW'(m_occ != 0));
        chk("occupancy", SW'(occupancy), SW'(m_occ));
        chk("tx_count", SW'(tx_count), SW'(m_tx));
        chk("loop_hold", loop_stream, m_last_loop);
        chk("loop_valid", SW'(loop_valid), SW'(loop_q.size() != 0));
        if (m_rst) chk("out_stream_rst", out_stream, '0);
        if (loop_valid && loop_q.size() != 0) begin
            e = loop_q.pop_front();
            chk("loop_stream", loop_stream, e);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", out_stream, '0);
                if (out_stream == '0) chk("unexpected_out_valid", SW'(out_valid), SW'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out_stream", out_stream, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic v, input logic [1:0] x, input logic [1:0] y,
                       input logic [PW-1:0] p, input logic ordy);
        req_valid = v; req_dst_x = x; req_dst_y = y; req_payload = p; out_ready = ordy;
        step();
    endtask

    initial begin
        logic [159:0] r;
        rst_n = 1'b0; req_valid = 1'b1; req_dst_x = 2'd2; req_dst_y = 2'd2;
        req_payload = 140'h7; out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        req(1'b1, 2'd2, 2'd2, 140'h7, 1'b1);
        req(1'b0, 2'd0, 2'd0, 140'h0, 1'b1);

        // single packet toward (2,1)
        req(1'b1, 2'd2, 2'd1, 140'hABC, 1'b1);
        #1;
        chk("single_valid", SW'(out_valid), SW'(1));
        chk("single_hdr", SW'(out_stream[143:140]), SW'(4'b0110));
        chk("single_pay", SW'(out_stream[139:0]), SW'(140'hABC));
        req(1'b0, 2'd0, 2'd0, 140'h0, 1'b1);
        chk("single_tx", SW'(tx_count), SW'(16'd2));
        chk("single_occ", SW'(occupancy), SW'(3'd0));

        // fill under backpressure, then drain in order
        for (int i = 1; i <= 4; i++) req(1'b1, 2'd0, 2'd0, PW'(i), 1'b0);
        req_valid = 1'b1; req_payload = 140'h99;
        #1;
        chk("full_ready", SW'(req_ready), SW'(0));
        chk("full_occ", SW'(occupancy), SW'(3'd4));
        step();
        step();
        chk("full_head", SW'(out_stream[139:0]), SW'(140'h1));
        for (int i = 0; i < 4; i++) req(1'b0, 2'd0, 2'd0, 140'h0, 1'b1);
        chk("full_tx", SW'(tx_count), SW'(16'd6));

        // simultaneous push/pop with pointer wrap
        for (int i = 0; i < 2; i++) req(1'b1, 2'd2, 2'd2, PW'(10 + i), 1'b0);
        for (int i = 0; i < 6; i++) req(1'b1, 2'd3, 2'd0, PW'(20 + i), 1'b1);
        chk("pp_occ", SW'(occupancy), SW'(3'd2));
        for (int i = 0; i < 2; i++) req(1'b0, 2'd0, 2'd0, 140'h0, 1'b1);

        // loopback while the FIFO is full
        for (int i = 0; i < 4; i++) req(1'b1, 2'd0, 2'd1, PW'(40 + i), 1'b0);
        req(1'b1, 2'd1, 2'd1, 140'h55, 1'b0);
        #1;
        chk("loop_pulse", SW'(loop_valid), SW'(1));
        chk("loop_hdr", SW'(loop_stream[143:140]), SW'(4'b0101));
        chk("loop_occ", SW'(occupancy), SW'(3'd4));
        chk("loop_tx", SW'(tx_count), SW'(16'd14));
        req(1'b0, 2'd0, 2'd0, 140'h0, 1'b0);
        #1;
        chk("loop_single", SW'(loop_valid), SW'(0));
        for (int i = 0; i < 4; i++) req(1'b0, 2'd0, 2'd0, 140'h0, 1'b1);

        // reset with three packets stalled
        for (int i = 0; i < 3; i++) req(1'b1, 2'd3, 2'd3, PW'(60 + i), 1'b0);
        rst_n = 1'b0;
        req(1'b0, 2'd0, 2'd0, 140'h0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_occ", SW'(occupancy), SW'(3'd0));
        chk("rst_valid", SW'(out_valid), SW'(0));
        chk("rst_tx", SW'(tx_count), SW'(16'd0));
        for (int i = 0; i < 3; i++) req(1'b0, 2'd0, 2'd0, 140'h0, 1'b1);

        // randomized traffic, biased toward self-addressed requests
        for (int i = 0; i < 600; i++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 4) == 0) begin
                req(1'($urandom_range(0, 1)), 2'd1, 2'd1, r[139:0], 1'($urandom_range(0, 1)));
            end else begin
                req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    r[139:0], 1'($urandom_range(0, 2) != 0));
            end
        end

        req_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        step();
        chk("drain", SW'(exp_q.size()), SW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
